// File: rtl/core_seq_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the single-issue NPC core.
// Optional simulation trace output is enabled with the CORE_SEQ_TRACE_EN macro.
module core_seq_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output logic                 o_ifu_req,
    input  logic                 i_ifu_ack,
    output logic                 o_ir_wen,
    input  logic                 i_is_load,
    input  logic                 i_is_store,
    input  logic                 i_rdwen,
    input  logic                 i_ebreak,
    input  logic                 i_illegal,
    output logic                 o_lsu_req,
    input  logic                 i_lsu_ack,
    output logic                 o_rf_wen,
    output logic                 o_pc_wen,
    output logic                 o_retire,
    output logic [CNT_WIDTH-1:0] o_retire_cnt,
    output logic [2:0]           o_state,
    output logic                 o_halt,
    output logic                 o_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    // The wait counter only ever needs to hold TIMEOUT_CYC-1.
    localparam int TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TMO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [TW-1:0] TMO_LAST = TMO_LAST_I[TW-1:0];

    state_t               state_reg, state_next;
    logic [TW-1:0]        tmo_reg, tmo_next;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic                 tmo_hit;

    assign tmo_hit      = (TIMEOUT_CYC != 0) && (tmo_reg == TMO_LAST);
    assign o_state      = state_reg;
    assign o_retire_cnt = cnt_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= S_IDLE;
            tmo_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tmo_reg   <= tmo_next;
            if (state_reg == S_WB)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // The wait counter is held at zero outside IF/MEM, so it is already
    // clear on every entry to either waiting state.
    always_comb begin
        state_next = state_reg;
        tmo_next   = '0;
        o_ifu_req  = 1'b0;
        o_ir_wen   = 1'b0;
        o_lsu_req  = 1'b0;
        o_rf_wen   = 1'b0;
        o_pc_wen   = 1'b0;
        o_retire   = 1'b0;
        o_halt     = 1'b0;
        o_err      = 1'b0;
        case (state_reg)
            S_IDLE: state_next = S_IF;
            S_IF: begin
                o_ifu_req = 1'b1;
                if (i_ifu_ack) begin
                    o_ir_wen   = 1'b1;
                    state_next = S_ID;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            S_ID: begin
                if (i_illegal)
                    state_next = S_ERR;
                else if (i_ebreak)
                    state_next = S_HALT;
                else
                    state_next = S_EX;
            end
            S_EX: state_next = (i_is_load || i_is_store) ? S_MEM : S_WB;
            S_MEM: begin
                o_lsu_req = 1'b1;
                if (i_lsu_ack)
                    state_next = S_WB;
                else if (tmo_hit)
                    state_next = S_ERR;
                else
                    tmo_next = tmo_reg + 1'b1;
            end
            S_WB: begin
                o_rf_wen   = i_rdwen & ~i_is_store;
                o_pc_wen   = 1'b1;
                o_retire   = 1'b1;
                state_next = S_IF;
            end
            // Flags are masked while reset is held so they read 0 before the edge too.
            S_HALT: o_halt = i_rst_n;
            S_ERR:  o_err  = i_rst_n;
            default: state_next = S_IDLE;
        endcase
    end

`ifdef CORE_SEQ_TRACE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (o_retire)
                $display("[core_seq_ctrl] retire #%0d rf_wen=%0b", cnt_reg + 1'b1, o_rf_wen);
            if (state_next == S_HALT && state_reg != S_HALT)
                $display("[core_seq_ctrl] HIT EBREAK after %0d retired", cnt_reg);
            if (state_next == S_ERR && state_reg != S_ERR) begin
                if (state_reg == S_ID)
                    $display("[core_seq_ctrl] error: illegal instruction");
                else if (state_reg == S_IF)
                    $display("[core_seq_ctrl] error: timeout on ifu port");
                else
                    $display("[core_seq_ctrl] error: timeout on lsu port");
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomized scoreboard bench for core_seq_ctrl: a driver walks instructions
// through the phases and queues expected events; a monitor checks them.
module tb_core_seq_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 4;

    localparam logic [2:0] S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_EBREAK = 3, K_ILLEGAL = 4;
    localparam int EV_RETIRE = 0, EV_HALT = 1, EV_ERR = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ifu_ack = 1'b0, lsu_ack = 1'b0;
    logic is_load = 1'b0, is_store = 1'b0, rdwen = 1'b0, ebreak = 1'b0, illegal = 1'b0;
    logic          ifu_req, ir_wen, lsu_req, rf_wen, pc_wen, retire, halt, err;
    logic [CW-1:0] retire_cnt;
    logic [2:0]    state;

    core_seq_ctrl #(.TIMEOUT_CYC(TMO), .CNT_WIDTH(CW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_ifu_req   (ifu_req),
        .i_ifu_ack   (ifu_ack),
        .o_ir_wen    (ir_wen),
        .i_is_load   (is_load),
        .i_is_store  (is_store),
        .i_rdwen     (rdwen),
        .i_ebreak    (ebreak),
        .i_illegal   (illegal),
        .o_lsu_req   (lsu_req),
        .i_lsu_ack   (lsu_ack),
        .o_rf_wen    (rf_wen),
        .o_pc_wen    (pc_wen),
        .o_retire    (retire),
        .o_retire_cnt(retire_cnt),
        .o_state     (state),
        .o_halt      (halt),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cnt;
        int rf;
        int ifu;
        int lsu;
        int ir;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cnt_model = 0;
    int   mon_ifu = 0, mon_lsu = 0, mon_ir = 0;
    bit   mon_ph = 1'b0, mon_pe = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int rnd_delay();
        return ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, TMO - 1);
    endfunction

    task automatic step(input logic [2:0] st, input string name);
        check(name, int'(state), int'(st));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ifu_ack = 1'($urandom);
        lsu_ack = 1'($urandom);
        @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_cnt", int'(retire_cnt), 0);
        check("rst_outputs", int'({halt, err, ifu_req, lsu_req, pc_wen, retire, rf_wen, ir_wen}), 0);
        check("rst_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        cnt_model = 0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ifu_ack = 1'b0;
        lsu_ack = 1'b0;
        illegal = 1'b0;
        ebreak  = 1'b0;
        step(S_IDLE, "idle_state");
    endtask

    // Drives one instruction from IF onwards; term reports HALT(1) / ERR(2) / none(0).
    task automatic run_instr(input int kind, input int d_if, input int d_lsu,
                             input bit rd, input bit eb_too, output int term);
        int   n_if;
        int   n_lsu;
        exp_t e;
        term     = 0;
        is_load  = (kind == K_LOAD);
        is_store = (kind == K_STORE);
        rdwen    = rd;
        illegal  = (kind == K_ILLEGAL);
        ebreak   = (kind == K_EBREAK) || (kind == K_ILLEGAL && eb_too);
        n_if     = (d_if < TMO) ? d_if : TMO;
        for (int k = 0; k < n_if; k++) begin
            ifu_ack = 1'b0;
            lsu_ack = 1'($urandom);
            step(S_IF, "if_wait_state");
        end
        e.cnt = cnt_model; e.rf = 0; e.lsu = 0; e.ir = 1; e.ifu = n_if + 1;
        if (d_if >= TMO) begin
            e.kind = EV_ERR; e.ifu = TMO; e.ir = 0;
            exp_q.push_back(e);
            lsu_ack = 1'b0;
            term = 2;
            return;
        end
        ifu_ack = 1'b1;
        lsu_ack = 1'($urandom);
        step(S_IF, "if_ack_state");
        ifu_ack = 1'($urandom);
        lsu_ack = 1'($urandom);
        if (illegal || ebreak) begin
            e.kind = illegal ? EV_ERR : EV_HALT;
            exp_q.push_back(e);
            step(S_ID, "id_state");
            term = illegal ? 2 : 1;
            return;
        end
        step(S_ID, "id_state");
        ifu_ack = 1'($urandom);
        lsu_ack = 1'($urandom);
        step(S_EX, "ex_state");
        if (is_load || is_store) begin
            n_lsu = (d_lsu < TMO) ? d_lsu : TMO;
            for (int k = 0; k < n_lsu; k++) begin
                lsu_ack = 1'b0;
                ifu_ack = 1'($urandom);
                step(S_MEM, "mem_wait_state");
            end
            e.lsu = n_lsu + 1;
            if (d_lsu >= TMO) begin
                e.kind = EV_ERR; e.lsu = TMO;
                exp_q.push_back(e);
                ifu_ack = 1'b0;
                term = 2;
                return;
            end
            lsu_ack = 1'b1;
            ifu_ack = 1'($urandom);
            step(S_MEM, "mem_ack_state");
        end
        e.kind = EV_RETIRE;
        e.rf   = (rd && !is_store) ? 1 : 0;
        exp_q.push_back(e);
        cnt_model = (cnt_model + 1) % (1 << CW);
        ifu_ack = 1'($urandom);
        lsu_ack = 1'($urandom);
        step(S_WB, "wb_state");
        ifu_ack = 1'b0;
        lsu_ack = 1'b0;
    endtask

    // Terminal states must hold with no requests or strobes whatever the inputs do.
    task automatic hold(input int term, input int ncyc);
        logic [10:0] expv;
        expv = (term == 1) ? {3'd6, 1'b1, 1'b0, 6'b0} : {3'd7, 1'b0, 1'b1, 6'b0};
        for (int k = 0; k < ncyc; k++) begin
            ifu_ack = 1'($urandom); lsu_ack = 1'($urandom);
            is_load = 1'($urandom); rdwen = 1'($urandom);
            illegal = 1'($urandom); ebreak = 1'($urandom);
            @(posedge clk);
            #1;
            check((term == 1) ? "halt_hold" : "err_hold",
                  int'({state, halt, err, ifu_req, lsu_req, pc_wen, retire, rf_wen, ir_wen}),
                  int'(expv));
        end
    endtask

    // A reset arriving while MEM is waiting must drop the request after the edge.
    task automatic do_abort();
        is_load = 1'b1; is_store = 1'b0; illegal = 1'b0; ebreak = 1'b0; rdwen = 1'b1;
        ifu_ack = 1'b1;
        step(S_IF, "abort_if_state");
        ifu_ack = 1'b0;
        step(S_ID, "abort_id_state");
        step(S_EX, "abort_ex_state");
        lsu_ack = 1'b0;
        step(S_MEM, "abort_mem_state");
        check("abort_lsu_req_pending", int'(lsu_req), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_lsu_req_dropped", int'(lsu_req), 0);
        check("abort_state", int'(state), 0);
    endtask

    initial begin : monitor
        int   ak;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_ifu = 0; mon_lsu = 0; mon_ir = 0;
                mon_ph = 1'b0; mon_pe = 1'b0;
            end else begin
                if (ifu_req) mon_ifu++;
                if (lsu_req) mon_lsu++;
                if (ir_wen)  mon_ir++;
                check("pc_wen_vs_retire", int'(pc_wen), int'(retire));
                if (!retire) check("rf_wen_outside_wb", int'(rf_wen), 0);
                if (retire || (halt && !mon_ph) || (err && !mon_pe)) begin
                    ak = retire ? EV_RETIRE : (halt ? EV_HALT : EV_ERR);
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", ak, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", ak, e.kind);
                        check("retire_cnt", int'(retire_cnt), e.cnt);
                        if (e.kind == EV_RETIRE) check("rf_wen", int'(rf_wen), e.rf);
                        check("ifu_req_cycles", mon_ifu, e.ifu);
                        check("lsu_req_cycles", mon_lsu, e.lsu);
                        check("ir_wen_pulses", mon_ir, e.ir);
                    end
                    mon_ifu = 0; mon_lsu = 0; mon_ir = 0;
                end
                mon_ph = halt;
                mon_pe = err;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int t;
        do_reset();
        run_instr(K_ALU, 0, 0, 1'b1, 1'b0, t);
        run_instr(K_LOAD, 0, 3, 1'b1, 1'b0, t);
        run_instr(K_STORE, 1, 0, 1'b1, 1'b0, t);
        run_instr(K_EBREAK, 0, 0, 1'b0, 1'b0, t);
        hold(1, 20);

        do_reset();
        run_instr(K_ALU, TMO, 0, 1'b1, 1'b0, t);
        hold(2, 5);

        do_reset();
        run_instr(K_ALU, TMO - 1, 0, 1'b1, 1'b0, t);
        run_instr(K_LOAD, 2, TMO - 1, 1'b1, 1'b0, t);
        run_instr(K_ILLEGAL, 0, 0, 1'b1, 1'b1, t);
        hold(2, 5);

        // Enough retires to wrap the narrow counter, then a data-port timeout.
        do_reset();
        for (int i = 0; i < 18; i++)
            run_instr(K_ALU, $urandom_range(0, 1), 0, 1'($urandom), 1'b0, t);
        run_instr(K_STORE, 0, TMO, 1'b1, 1'b0, t);
        hold(2, 5);

        do_reset();
        run_instr(K_ALU, 0, 0, 1'b1, 1'b0, t);
        do_abort();

        for (int ep = 0; ep < 30; ep++) begin
            int n;
            int r;
            do_reset();
            n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++)
                run_instr($urandom_range(0, 2), rnd_delay(), rnd_delay(), 1'($urandom), 1'b0, t);
            r = $urandom_range(0, 4);
            t = 0;
            case (r)
                0: run_instr(K_EBREAK, rnd_delay(), 0, 1'($urandom), 1'b0, t);
                1: run_instr(K_ILLEGAL, rnd_delay(), 0, 1'($urandom), 1'($urandom), t);
                2: run_instr($urandom_range(0, 2), TMO + $urandom_range(0, 3), 0, 1'($urandom), 1'b0, t);
                3: run_instr($urandom_range(1, 2), rnd_delay(), TMO + $urandom_range(0, 3), 1'($urandom), 1'b0, t);
                default: do_abort();
            endcase
            if (t != 0) hold(t, $urandom_range(3, 10));
        end

        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the single-issue NPC core. It steps each instruction through fetch, decode, execute, memory and writeback. It handshakes with the instruction and data memory ports, and qualifies decoder outputs into one-cycle write strobes for the instruction register, register file and PC. It sits between the IFU/LSU memory interfaces and the decoder/EXU datapath, and owns halt, error and retire accounting.

Parameters:
TIMEOUT_CYC, 255, max cycles waiting for i_ifu_ack or i_lsu_ack before entering ERR; 0 disables the timeout.
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
i_clk  in  1  core clock, all state on rising edge
i_rst_n  in  1  reset i_rst_n, synchronous, active-low
o_ifu_req  out  1  instruction fetch request, held while waiting
i_ifu_ack  in  1  fetch data valid this cycle
o_ir_wen  out  1  latch instruction register
i_is_load  in  1  decoded instruction is a load
i_is_store  in  1  decoded instruction is a store
i_rdwen  in  1  decoded rd write enable
i_ebreak  in  1  decoded ebreak
i_illegal  in  1  decoder reports opcode/func3/func7 error
o_lsu_req  out  1  data memory request, held while waiting
i_lsu_ack  in  1  data access complete this cycle
o_rf_wen  out  1  register file write strobe
o_pc_wen  out  1  PC update strobe (next-PC selection owned by PCU)
o_retire  out  1  one-cycle pulse per retired instruction
o_retire_cnt  out  CNT_WIDTH  retired instruction count
o_state  out  3  current state encoding
o_halt  out  1  ebreak reached, sticky
o_err  out  1  illegal instruction or timeout, sticky

Behaviour:
- States and encoding: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6, ERR=7. o_state is the registered state.
- Reset (i_rst_n=0 at clock edge): state=IDLE, o_retire_cnt=0, timeout counter=0. All strobes are 0, and o_halt=o_err=0 during and after reset.
- Reset mid-operation aborts any pending request; o_ifu_req and o_lsu_req drop the cycle after the reset edge.
- IDLE: goes to IF unconditionally on the next cycle.
- IF: o_ifu_req=1.
  - On i_ifu_ack=1: o_ir_wen=1 in the same cycle (combinational from state and ack), then go to ID.
- ID: all strobes 0.
  - i_illegal has priority: go to ERR.
  - Else if i_ebreak: go to HALT.
  - Else: go to EX.
- EX: if i_is_load or i_is_store, go to MEM; otherwise go to WB.
- MEM: o_lsu_req=1 until i_lsu_ack=1, then go to WB.
- WB, single cycle:
  - o_rf_wen = i_rdwen & ~i_is_store.
  - o_pc_wen=1 and o_retire=1.
  - o_retire_cnt increments at the clock edge, wrapping from all-ones to 0.
  - Next state is IF.
- HALT and ERR: absorbing until reset. o_halt=1 in HALT; o_err=1 in ERR. No requests or strobes are issued.
- Strobes o_pc_wen, o_rf_wen, o_retire, o_lsu_req and o_ifu_req are Moore decodes of the registered state, except o_ir_wen and o_rf_wen as defined above.
- Timeout:
  - The counter clears on entry to IF or MEM.
  - It increments each waiting cycle without ack.
  - When it reaches TIMEOUT_CYC-1 with no ack, the next state is ERR.
  - An ack arriving in that same cycle wins: normal transition, no error.
- Minimum latency: 5 cycles per ALU instruction (IF with same-cycle ack, ID, EX, WB, plus the IDLE cycle once after reset only; steady state is 4 cycles). Load/store with same-cycle ack takes 5 cycles.
- i_ifu_ack outside IF and i_lsu_ack outside MEM are ignored.

Optional Feature:
CORE_SEQ_TRACE_EN
- Defined:
  - Simulation-only $display on every o_retire, showing o_retire_cnt and whether rf was written.
  - On entry to ERR, $display of the cause (illegal or timeout, and which port), then $finish.
  - On entry to HALT, $display "HIT EBREAK" with the retire count.
- Undefined: no display code; RTL behaviour is otherwise identical.

Test Plan:
- Reset, then ALU instr with i_ifu_ack high every IF and i_rdwen=1 -> states 0,1,2,3,5,1; o_rf_wen and o_pc_wen are high exactly in cycle 4; o_retire_cnt=1.
- Load with i_lsu_ack delayed 3 cycles -> o_lsu_req high 4 cycles, then WB with o_rf_wen=1.
- Store with i_rdwen=1 -> o_rf_wen stays 0 in WB; o_pc_wen=1.
- i_ebreak in ID -> o_state=6 and o_halt=1 held for 20 cycles; no o_ifu_req; i_rst_n=0 returns to IDLE with count 0.
- i_ifu_ack withheld with TIMEOUT_CYC=4 -> ERR after 4 IF cycles; a second run with ack on the 4th wait cycle proceeds to ID with o_err=0.
- i_illegal and i_ebreak both high in ID -> ERR (illegal priority); o_retire_cnt unchanged.
